alu_issue_ctrl: RTL and testbench

- Issue and sequencing end of the mini-core datapath: accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 4x16 register file and drives opcode/operands to the combinational ALU.
- Captures the ALU result and writes it back, executing one instruction at a time.
- Sits between the instruction source (testbench or fetch) and the `alu` instance, which lives outside this block.

---
 rtl/mini_core_pkg.sv | 35 +++
 rtl/alu_regfile.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 58 +++++
 tb/tb_alu_issue_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mini_core_pkg.sv
// mini_core_pkg: opcodes, instruction layout and FSM encoding shared by the issue control and the ALU.
package mini_core_pkg;
    localparam int INSTR_W = 16;
    localparam int REG_AW  = 2;
    localparam int OP_LSB     = 13;
    localparam int RD_LSB     = 11;
    localparam int RS1_LSB    = 9;
    localparam int RS2_LSB    = 7;
    localparam int IMM_EN_BIT = 6;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              imm_en;
    } dec_t;
    function automatic dec_t decode(input logic [INSTR_W-1:0] w);
        decode.op     = w[OP_LSB+:3];
        decode.rd     = w[RD_LSB+:REG_AW];
        decode.rs1    = w[RS1_LSB+:REG_AW];
        decode.rs2    = w[RS2_LSB+:REG_AW];
        decode.imm_en = w[IMM_EN_BIT];
    endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4-entry register file, async clear, one write port, three combinational read ports.
module alu_regfile
    import mini_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3
);
    logic [DATA_W-1:0] regs [2**REG_AW];
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        else if (we)
            regs[waddr] <= wdata;
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
    assign rd3 = regs[ra3];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to an external ALU and writes its result back.
module alu_issue_ctrl
    import mini_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [2:0]         alu_opcode,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               done,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               busy,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);
    logic [1:0]        state;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] res_q, rs1_data, rs2_data;
    dec_t              d;
    assign d           = decode(instr);
    assign instr_ready = state == S_IDLE;
    assign busy        = !instr_ready;
    assign done        = state == S_WB;
    assign wb_rd       = done ? rd_q : '0;
    assign wb_data     = done ? res_q : '0;
    alu_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk(clk), .rst(rst), .we(done), .waddr(rd_q), .wdata(res_q),
        .ra1(d.rs1), .ra2(d.rs2), .ra3(dbg_sel),
        .rd1(rs1_data), .rd2(rs2_data), .rd3(dbg_data)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= S_IDLE;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_q       <= '0;
            res_q      <= '0;
        end else if (state == S_IDLE && instr_valid) begin
            state      <= S_EXEC;
            alu_opcode <= d.op;
            alu_a      <= rs1_data;
            alu_b      <= d.imm_en ? DATA_W'(instr[IMM_W-1:0]) : rs2_data;
            rd_q       <= d.rd;
        end else if (state == S_EXEC) begin
            state <= S_WB;
            res_q <= alu_result;
        end else if (state == S_WB)
            state <= S_IDLE;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against a behavioural ALU, with hand-computed expectations.
module tb_alu_issue_ctrl;
    logic        clk = 0, rst = 1, instr_valid = 0;
    logic [15:0] instr = '0;
    logic [1:0]  dbg_sel = '0;
    logic        instr_ready, done, busy;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
    logic [1:0]  wb_rd;
    int vectors = 0, miscompares = 0, done_cnt = 0, base, n;

    alu_issue_ctrl #(.DATA_W(16), .IMM_W(6)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .done(done), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_a * alu_b;
            3'd6: alu_result = alu_a << alu_b[3:0];
            default: alu_result = alu_a >> alu_b[3:0];
        endcase
    end

    task automatic send(input logic [15:0] w);
        @(negedge clk);
        instr = w;
        instr_valid = 1;
        @(posedge clk);
        #1 instr_valid = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", instr_ready); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b exp 0", done); end
        vectors++; if ({alu_opcode, alu_a, alu_b} !== 35'd0) begin miscompares++; $display("FAIL rst_alu got %h/%h/%h exp 0", alu_opcode, alu_a, alu_b); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            vectors++; if (dbg_data !== 16'h0) begin miscompares++; $display("FAIL rst_reg%0d got %h exp 0000", i, dbg_data); end
        end
        @(negedge clk) rst = 0;
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_ready got %b/%b exp 1/0", instr_ready, busy); end
    endtask

    task automatic test_imm_loads;
        send(16'h0845);
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL done_latency got %0d exp 2", n); end
        vectors++; if (wb_rd !== 2'd1 || wb_data !== 16'h0005) begin miscompares++; $display("FAIL wb_r1 got %0d/%h exp 1/0005", wb_rd, wb_data); end
        @(negedge clk);
        dbg_sel = 2'd1;
        #1;
        vectors++; if (dbg_data !== 16'h0005 || done !== 1'b0 || instr_ready !== 1'b1) begin miscompares++; $display("FAIL r1_after got %h/%b/%b exp 0005/0/1", dbg_data, done, instr_ready); end
        send(16'h1047);
        repeat (2) @(negedge clk);
        vectors++; if (done !== 1'b1 || wb_rd !== 2'd2 || wb_data !== 16'h0007) begin miscompares++; $display("FAIL wb_r2 got %b/%0d/%h exp 1/2/0007", done, wb_rd, wb_data); end
        @(negedge clk);
        dbg_sel = 2'd2;
        #1;
        vectors++; if (dbg_data !== 16'h0007) begin miscompares++; $display("FAIL r2_after got %h exp 0007", dbg_data); end
    endtask

    task automatic test_sub;
        send(16'h3B00);
        @(negedge clk);
        vectors++; if (alu_opcode !== 3'b001 || alu_a !== 16'h0005 || alu_b !== 16'h0007) begin miscompares++; $display("FAIL sub_exec got %b/%h/%h exp 001/0005/0007", alu_opcode, alu_a, alu_b); end
        vectors++; if (busy !== 1'b1 || instr_ready !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL sub_busy got %b/%b/%b exp 1/0/0", busy, instr_ready, done); end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || wb_rd !== 2'd3 || wb_data !== 16'hFFFE) begin miscompares++; $display("FAIL sub_wb got %b/%0d/%h exp 1/3/fffe", done, wb_rd, wb_data); end
        vectors++; if (alu_opcode !== 3'b001 || alu_a !== 16'h0005 || alu_b !== 16'h0007) begin miscompares++; $display("FAIL sub_hold got %b/%h/%h exp 001/0005/0007", alu_opcode, alu_a, alu_b); end
        @(negedge clk);
        dbg_sel = 2'd3;
        #1;
        vectors++; if (dbg_data !== 16'hFFFE) begin miscompares++; $display("FAIL r3_after got %h exp fffe", dbg_data); end
    endtask

    task automatic test_mul;
        send(16'hA780);
        @(negedge clk);
        vectors++; if (alu_opcode !== 3'b101 || alu_a !== 16'hFFFE || alu_b !== 16'hFFFE) begin miscompares++; $display("FAIL mul_exec got %b/%h/%h exp 101/fffe/fffe", alu_opcode, alu_a, alu_b); end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || wb_rd !== 2'd0 || wb_data !== 16'h0004) begin miscompares++; $display("FAIL mul_wb got %b/%0d/%h exp 1/0/0004", done, wb_rd, wb_data); end
        @(negedge clk);
        dbg_sel = 2'd0;
        #1;
        vectors++; if (dbg_data !== 16'h0004) begin miscompares++; $display("FAIL r0_after got %h exp 0004", dbg_data); end
    endtask

    task automatic test_back_to_back;
        base = done_cnt;
        @(negedge clk);
        instr = 16'h0841;
        instr_valid = 1;
        @(negedge clk);
        vectors++; if (alu_opcode !== 3'b000 || alu_a !== 16'h0004 || alu_b !== 16'h0001) begin miscompares++; $display("FAIL bp1_exec got %b/%h/%h exp 000/0004/0001", alu_opcode, alu_a, alu_b); end
        instr = 16'h1042;
        @(negedge clk);
        vectors++; if (done !== 1'b1 || wb_rd !== 2'd1 || wb_data !== 16'h0005) begin miscompares++; $display("FAIL bp1_wb got %b/%0d/%h exp 1/1/0005", done, wb_rd, wb_data); end
        instr = 16'h7A70;
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL bp_idle got %b/%b exp 1/0", instr_ready, done); end
        @(negedge clk);
        vectors++; if (alu_opcode !== 3'b011 || alu_a !== 16'h0005 || alu_b !== 16'h0030) begin miscompares++; $display("FAIL bp2_exec got %b/%h/%h exp 011/0005/0030", alu_opcode, alu_a, alu_b); end
        instr_valid = 0;
        @(negedge clk);
        vectors++; if (done !== 1'b1 || wb_rd !== 2'd3 || wb_data !== 16'h0035) begin miscompares++; $display("FAIL bp2_wb got %b/%0d/%h exp 1/3/0035", done, wb_rd, wb_data); end
        repeat (4) @(negedge clk);
        dbg_sel = 2'd2;
        #1;
        vectors++; if (dbg_data !== 16'h0007) begin miscompares++; $display("FAIL bp_r2_untouched got %h exp 0007", dbg_data); end
        vectors++; if (done_cnt - base !== 2) begin miscompares++; $display("FAIL bp_done_count got %0d exp 2", done_cnt - base); end
    endtask

    task automatic test_reset_abort;
        base = done_cnt;
        send(16'h0845);
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_in_exec got %b exp 1", busy); end
        rst = 1;
        #1;
        dbg_sel = 2'd1;
        #1;
        vectors++; if (instr_ready !== 1'b1 || done !== 1'b0 || dbg_data !== 16'h0000) begin miscompares++; $display("FAIL abort_rst got %b/%b/%h exp 1/0/0000", instr_ready, done, dbg_data); end
        @(negedge clk) rst = 0;
        repeat (3) @(negedge clk);
        vectors++; if (done_cnt - base !== 0 || dbg_data !== 16'h0000 || instr_ready !== 1'b1) begin miscompares++; $display("FAIL abort_after got %0d/%h/%b exp 0/0000/1", done_cnt - base, dbg_data, instr_ready); end
        send(16'h0845);
        repeat (2) @(negedge clk);
        vectors++; if (done !== 1'b1 || wb_rd !== 2'd1 || wb_data !== 16'h0005) begin miscompares++; $display("FAIL abort_next_wb got %b/%0d/%h exp 1/1/0005", done, wb_rd, wb_data); end
        @(negedge clk);
        #1;
        vectors++; if (dbg_data !== 16'h0005) begin miscompares++; $display("FAIL abort_next_r1 got %h exp 0005", dbg_data); end
    endtask

    initial begin
        test_reset;
        test_imm_loads;
        test_sub;
        test_mul;
        test_back_to_back;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
